// File: rtl/mcycle_mul_div_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes,
// FSM states and default geometry.
package mcycle_mul_div_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 6;

  // bit1 selects divide, bit0 selects unsigned
  typedef enum logic [1:0] {
    MUL_S = 2'b00,
    MUL_U = 2'b01,
    DIV_S = 2'b10,
    DIV_U = 2'b11
  } mcycle_op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_COMPUTE = 2'b01,
    ST_DONE    = 2'b10
  } state_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mcycle_mul_div_if.sv
// Request/response bundle between the E-stage datapath and the multi-cycle
// multiply/divide unit.
interface mcycle_mul_div_if #(
  parameter int WIDTH = mcycle_mul_div_pkg::WIDTH_DEF
);

  logic             Start;
  logic [1:0]       MCycleOp;
  logic [WIDTH-1:0] Operand1;
  logic [WIDTH-1:0] Operand2;
  logic [WIDTH-1:0] Result1;
  logic [WIDTH-1:0] Result2;
  logic             Busy;

  modport master (
    output Start, MCycleOp, Operand1, Operand2,
    input  Result1, Result2, Busy
  );

  modport slave (
    input  Start, MCycleOp, Operand1, Operand2,
    output Result1, Result2, Busy
  );

endinterface

// File: rtl/mcycle_mul_div_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial
// subtract the divisor, keep the difference only when it is non-negative.
module mcycle_mul_div_div_step #(
  parameter int WIDTH = mcycle_mul_div_pkg::WIDTH_DEF
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             dividend_bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem_i < divisor, so the WIDTH+1-bit difference cannot wrap and its MSB is a true sign
  always_comb begin
    shifted = {rem_i, dividend_bit_i};
    diff    = shifted - {1'b0, divisor_i};
    q_bit_o = ~diff[WIDTH];
    rem_o   = q_bit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/mcycle_mul_div.sv
// Iterative multiply/divide unit for the Execute stage: one shift-add or
// restoring-divide iteration per cycle, Busy drives the pipeline stall.
module mcycle_mul_div
  import mcycle_mul_div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic           CLK,
  input  logic           RESET,
  mcycle_mul_div_if.slave bus
);

  if ((1 << CNT_W) <= WIDTH) begin : g_cnt_w_check
    $error("CNT_W too small for WIDTH");
  end

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [1:0]             op_q, op_d;
  logic [WIDTH-1:0]       a_q, a_d;
  logic [WIDTH-1:0]       b_q, b_d;
  logic [WIDTH-1:0]       raw1_q, raw1_d;
  logic                   sign1_q, sign1_d;
  logic                   sign2_q, sign2_d;
  logic [2*WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]       rem_q, rem_d;
  logic [WIDTH-1:0]       res1_q, res1_d;
  logic [WIDTH-1:0]       res2_q, res2_d;

  logic                   in_signed;
  logic [WIDTH-1:0]       op1_mag, op2_mag;
  logic [WIDTH:0]         mul_sum;
  logic [2*WIDTH-1:0]     mul_next;
  logic [2*WIDTH-1:0]     prod_fix;
  logic [WIDTH-1:0]       rem_next;
  logic                   q_bit;
  logic [WIDTH-1:0]       quo_next;
  logic [WIDTH-1:0]       quo_fix;
  logic [WIDTH-1:0]       rem_fix;
  logic                   last_iter;

  mcycle_mul_div_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i          (rem_q),
    .dividend_bit_i (acc_q[WIDTH-1]),
    .divisor_i      (b_q),
    .rem_o          (rem_next),
    .q_bit_o        (q_bit)
  );

  // Operand magnitudes and one iteration of each algorithm
  always_comb begin
    in_signed = op_is_signed(bus.MCycleOp);
    op1_mag   = (in_signed && bus.Operand1[WIDTH-1]) ? -bus.Operand1 : bus.Operand1;
    op2_mag   = (in_signed && bus.Operand2[WIDTH-1]) ? -bus.Operand2 : bus.Operand2;

    // Shift-add: low half holds the unconsumed multiplier bits
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    prod_fix  = (sign1_q ^ sign2_q) ? -mul_next : mul_next;

    // Most-negative / -1 falls out naturally: magnitude 2^(W-1), negated, wraps to itself
    quo_next  = {acc_q[WIDTH-2:0], q_bit};
    quo_fix   = (sign1_q ^ sign2_q) ? -quo_next : quo_next;
    rem_fix   = sign1_q ? -rem_next : rem_next;

    last_iter = (cnt_q == CNT_W'(WIDTH - 1));
  end

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    raw1_d  = raw1_q;
    sign1_d = sign1_q;
    sign2_d = sign2_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    res1_d  = res1_q;
    res2_d  = res2_q;
    bus.Busy = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.Start) begin
          bus.Busy = 1'b1;
          op_d     = bus.MCycleOp;
          a_d      = op1_mag;
          b_d      = op2_mag;
          raw1_d   = bus.Operand1;
          sign1_d  = in_signed & bus.Operand1[WIDTH-1];
          sign2_d  = in_signed & bus.Operand2[WIDTH-1];
          acc_d    = {{WIDTH{1'b0}}, op_is_div(bus.MCycleOp) ? op1_mag : op2_mag};
          rem_d    = '0;
          cnt_d    = '0;
          state_d  = ST_COMPUTE;
        end
      end

      ST_COMPUTE: begin
        bus.Busy = 1'b1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (op_is_div(op_q)) begin
          acc_d = {acc_q[2*WIDTH-1:WIDTH], quo_next};
          rem_d = rem_next;
        end else begin
          acc_d = mul_next;
        end

        if (last_iter) begin
          state_d = ST_DONE;
          if (!op_is_div(op_q)) begin
            res1_d = prod_fix[WIDTH-1:0];
            res2_d = prod_fix[2*WIDTH-1:WIDTH];
          end else if (b_q == '0) begin
            res1_d = '1;
            res2_d = raw1_q;
          end else begin
            res1_d = quo_fix;
            res2_d = rem_fix;
          end
        end
      end

      // A Start still high here belongs to the instruction just finished
      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      raw1_q  <= '0;
      sign1_q <= 1'b0;
      sign2_q <= 1'b0;
      acc_q   <= '0;
      rem_q   <= '0;
      res1_q  <= '0;
      res2_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      raw1_q  <= raw1_d;
      sign1_q <= sign1_d;
      sign2_q <= sign2_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      res1_q  <= res1_d;
      res2_q  <= res2_d;
    end
  end

  assign bus.Result1 = res1_q;
  assign bus.Result2 = res2_q;

endmodule

// File: tb/tb_mcycle_mul_div.sv
// Directed bench for mcycle_mul_div: reset behaviour, Busy timing, signed and
// unsigned multiply/divide, divide-by-zero, overflow and back-to-back launch.
module tb_mcycle_mul_div;
  import mcycle_mul_div_pkg::*;

  localparam int W = 32;

  logic CLK;
  logic RESET;
  int   tests;
  int   fails;

  mcycle_mul_div_if #(.WIDTH(W)) bus ();

  mcycle_mul_div #(.WIDTH(W), .CNT_W(6)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge with the unit in IDLE; returns #1 after the
  // edge that leaves DONE, with Start still high.
  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp1, input logic [W-1:0] exp2,
                        input bit toggle);
    int busy_cycles;
    bit done_seen;
    bus.Start    = 1'b1;
    bus.MCycleOp = op;
    bus.Operand1 = a;
    bus.Operand2 = b;
    #1;
    check({tag, " busy_cycle0"}, 64'(bus.Busy), 64'd1);
    busy_cycles = 1;
    done_seen   = 1'b0;
    @(posedge CLK);
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (!bus.Busy) begin
        done_seen = 1'b1;
        break;
      end
      busy_cycles++;
      if (toggle) begin
        bus.Operand1 = $urandom;
        bus.Operand2 = $urandom;
        bus.MCycleOp = 2'($urandom_range(3, 0));
      end
    end
    check({tag, " busy_len"}, 64'(busy_cycles), 64'd33);
    check({tag, " done_reached"}, 64'(done_seen), 64'd1);
    check({tag, " result1"}, 64'(bus.Result1), 64'(exp1));
    check({tag, " result2"}, 64'(bus.Result2), 64'(exp2));
    check({tag, " busy_done_start_high"}, 64'(bus.Busy), 64'd0);
    @(posedge CLK);
    #1;
  endtask

  // One cycle of IDLE without Start; results must stay put.
  task automatic idle_cycle(input string tag, input logic [W-1:0] exp1, input logic [W-1:0] exp2);
    bus.Start = 1'b0;
    @(negedge CLK);
    check({tag, " idle_busy"}, 64'(bus.Busy), 64'd0);
    check({tag, " held_r1"}, 64'(bus.Result1), 64'(exp1));
    check({tag, " held_r2"}, 64'(bus.Result2), 64'(exp2));
    @(posedge CLK);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    RESET        = 1'b1;
    bus.Start    = 1'b0;
    bus.MCycleOp = MUL_S;
    bus.Operand1 = '0;
    bus.Operand2 = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("reset busy", 64'(bus.Busy), 64'd0);
    check("reset r1", 64'(bus.Result1), 64'd0);
    check("reset r2", 64'(bus.Result2), 64'd0);
    RESET = 1'b0;
    @(posedge CLK);
    #1;

    // Load known non-zero results so the mid-op reset has something to clear
    run_op("mul_u_6x7_pre", MUL_U, 32'd6, 32'd7, 32'd42, 32'd0, 1'b0);
    idle_cycle("pre", 32'd42, 32'd0);

    // Reset mid-operation
    bus.Start    = 1'b1;
    bus.MCycleOp = MUL_U;
    bus.Operand1 = 32'hFFFF_FFFF;
    bus.Operand2 = 32'd2;
    repeat (10) @(posedge CLK);
    #2;
    RESET     = 1'b1;
    bus.Start = 1'b0;
    #1;
    check("midreset busy", 64'(bus.Busy), 64'd0);
    check("midreset r1", 64'(bus.Result1), 64'd0);
    check("midreset r2", 64'(bus.Result2), 64'd0);
    @(posedge CLK);
    #2;
    RESET = 1'b0;
    @(posedge CLK);
    #1;

    run_op("mul_u_max", MUL_U, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
    idle_cycle("mul_u_max", 32'h0000_0001, 32'hFFFF_FFFE);

    run_op("mul_s_m7x3", MUL_S, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0);
    idle_cycle("mul_s_m7x3", 32'hFFFF_FFEB, 32'hFFFF_FFFF);

    run_op("mul_s_m1xm1", MUL_S, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
    idle_cycle("mul_s_m1xm1", 32'd1, 32'd0);

    run_op("div_s_m7d2", DIV_S, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    idle_cycle("div_s_m7d2", 32'hFFFF_FFFD, 32'hFFFF_FFFF);

    run_op("div_s_7dm2", DIV_S, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);
    idle_cycle("div_s_7dm2", 32'hFFFF_FFFD, 32'd1);

    run_op("div_u_100d7", DIV_U, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    idle_cycle("div_u_100d7", 32'd14, 32'd2);

    run_op("div_u_5d0", DIV_U, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b0);
    idle_cycle("div_u_5d0", 32'hFFFF_FFFF, 32'd5);

    run_op("div_s_m5d0", DIV_S, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b0);
    idle_cycle("div_s_m5d0", 32'hFFFF_FFFF, 32'hFFFF_FFFB);

    run_op("div_s_ovf", DIV_S, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    idle_cycle("div_s_ovf", 32'h8000_0000, 32'd0);

    // Back-to-back: second Start in the IDLE cycle right after DONE, operands churn during COMPUTE
    run_op("b2b_div_u_9d4", DIV_U, 32'd9, 32'd4, 32'd2, 32'd1, 1'b1);
    run_op("b2b_mul_u_6x7", MUL_U, 32'd6, 32'd7, 32'd42, 32'd0, 1'b1);
    idle_cycle("b2b", 32'd42, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
